multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore FSM that sequences the multicycle MIPS datapath: fetch, decode, execute, memory and writeback on a shared memory and ALU.
- Decodes the 6-bit opcode from the instruction register and drives every mux select and write enable each cycle.
- Stalls on a memory ready handshake.
- Keeps a retired-instruction counter and a sticky illegal-opcode flag for debug.

Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26]; sampled only in DECODE
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write if ALU zero
- IorD  out  1  0=PC addresses memory, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load instruction register
- MemtoReg  out  1  1=MDR to register file, 0=ALUOut
- RegDst  out  1  1=rd, 0=rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct decode
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state, debug
- illegal_op  out  1  sticky; set on undecodable opcode
- instr_count  out  CNT_W  instructions retired, wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at edge):
  - state=FETCH(0), illegal_op=0, instr_count=0.
  - While rst is high, all control outputs are forced to 0.
  - Reset mid-instruction abandons it; no count is taken.
- Outputs are a pure function of state. Exceptions: PCWrite and IRWrite in FETCH equal mem_ready. Unlisted outputs are 0 in each state.
- Opcode map: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- State table:
  - 0 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Stays while !mem_ready; goes to 1 when ready.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next: lw/sw->2, R->6, beq->8, j->9, addi->10. Any other opcode -> 0 and sets illegal_op.
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw->3, sw->5. Uses the opcode latched at DECODE, not the live input.
  - 3 MEMRD: MemRead=1, IorD=1. Waits on mem_ready, then ->4.
  - 4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. ->0.
  - 5 MEMWR: MemWrite=1, IorD=1. Waits on mem_ready, then ->0.
  - 6 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. ->7.
  - 7 RCOMP: RegWrite=1, RegDst=1, MemtoReg=0. ->0.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. ->0.
  - 9 JUMP: PCWrite=1, PCSource=10. ->0.
  - 10 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. ->11.
  - 11 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. ->0.
  - 12-15: all outputs 0; ->0 next cycle; no count.
- Latency with zero wait (mem_ready always 1):
  - lw 5 cycles.
  - sw, R, addi 4 cycles.
  - beq, j 3 cycles.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- instr_count increments by 1 on the final-state exit edge of each instruction into FETCH: states 4, 5 (when ready), 7, 8, 9, 11.
  - Illegal opcodes and states 12-15 do not count.
  - Count wraps from all-ones to 0.
- illegal_op is cleared only by rst. The same cycle a new illegal opcode is seen, it stays 1.
- MemRead and MemWrite are never both 1. RegWrite and any memory strobe are never both 1.

Test Plan:
- Reset: assert rst for 2 cycles mid-MEMRD -> next cycle state=0, all strobes 0, instr_count=0, illegal_op=0.
- lw, mem_ready=1 -> state sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. instr_count 0->1 on the last edge.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 held for 4 cycles, total 7 cycles, count +1.
- R, beq, j, addi back-to-back -> sequences 0,1,6,7 / 0,1,8 / 0,1,9 / 0,1,10,11. PCWriteCond only in 8, PCSource=10 only in 9. instr_count=4.
- FETCH with mem_ready=0 for 5 cycles -> IRWrite=PCWrite=0 throughout; 1 only on the ready cycle.
- opcode=111111 at DECODE -> returns to 0, illegal_op=1 and sticky, count unchanged. Also preset instr_count to 0xFFFF, retire j -> count=0x0000.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller connects through "master"; a datapath model connects through "slave".
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, illegal_op, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, illegal_op, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore controller for the multicycle MIPS datapath: fetch/decode/execute/mem/writeback,
// stalling on mem_ready, with a retired-instruction counter and sticky illegal-opcode flag.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e           r_state;
  state_e           w_next;
  logic [5:0]       r_opcode;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;
  ctrl_t            w_ctrl;
  logic             w_illegal;
  logic             w_retire;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.opcode;
      if (w_illegal)           r_illegal <= 1'b1;
      if (w_retire)            r_count <= r_count + 1'b1;
    end
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next    = S_FETCH;
    w_ctrl    = '0;
    w_illegal = 1'b0;
    w_retire  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = 2'b01;
        w_ctrl.pc_write  = bus.mem_ready;
        w_ctrl.ir_write  = bus.mem_ready;
        w_next           = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b10;
        // IR may already be changing; branch on the opcode captured at decode.
        w_next = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
        w_next          = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_retire          = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
        w_retire         = bus.mem_ready;
        w_next           = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = 2'b10;
        w_next           = S_RCOMP;
      end
      S_RCOMP: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_retire         = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_op        = 2'b01;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = 2'b01;
        w_retire             = 1'b1;
      end
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = 2'b10;
        w_retire         = 1'b1;
      end
      S_ADDIEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b10;
        w_next           = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_ctrl.reg_write = 1'b1;
        w_retire         = 1'b1;
      end
      default: ;
    endcase
    if (rst) w_ctrl = '0;
  end

  assign bus.PCWrite     = w_ctrl.pc_write;
  assign bus.PCWriteCond = w_ctrl.pc_write_cond;
  assign bus.IorD        = w_ctrl.i_or_d;
  assign bus.MemRead     = w_ctrl.mem_read;
  assign bus.MemWrite    = w_ctrl.mem_write;
  assign bus.IRWrite     = w_ctrl.ir_write;
  assign bus.MemtoReg    = w_ctrl.mem_to_reg;
  assign bus.RegDst      = w_ctrl.reg_dst;
  assign bus.RegWrite    = w_ctrl.reg_write;
  assign bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign bus.ALUOp       = w_ctrl.alu_op;
  assign bus.PCSource    = w_ctrl.pc_source;
  assign bus.state       = r_state;
  assign bus.illegal_op  = r_illegal;
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second 4-bit-counter instance shares the
// inputs so counter wrap can be reached in a short run.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(16)) bus ();
  multicycle_ctrl_if #(.CNT_W(4))  bus_s ();

  assign bus_s.opcode    = bus.opcode;
  assign bus_s.mem_ready = bus.mem_ready;

  multicycle_ctrl #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  multicycle_ctrl #(.CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  logic [15:0] ctl;
  assign ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource};

  // Hand-written state table in the same bit order as ctl.
  function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic mr);
    logic [15:0] e;
    e = '0;
    case (s)
      4'd0:  begin e[15] = mr; e[12] = 1'b1; e[10] = mr; e[5:4] = 2'b01; end
      4'd1:  e[5:4] = 2'b11;
      4'd2:  begin e[6] = 1'b1; e[5:4] = 2'b10; end
      4'd3:  begin e[13] = 1'b1; e[12] = 1'b1; end
      4'd4:  begin e[7] = 1'b1; e[9] = 1'b1; end
      4'd5:  begin e[13] = 1'b1; e[11] = 1'b1; end
      4'd6:  begin e[6] = 1'b1; e[3:2] = 2'b10; end
      4'd7:  begin e[7] = 1'b1; e[8] = 1'b1; end
      4'd8:  begin e[6] = 1'b1; e[3:2] = 2'b01; e[14] = 1'b1; e[1:0] = 2'b01; end
      4'd9:  begin e[15] = 1'b1; e[1:0] = 2'b10; end
      4'd10: begin e[6] = 1'b1; e[5:4] = 2'b10; end
      4'd11: e[7] = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic test_reset();
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    logic       mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    #1;
    n_checks++;
    if (ctl !== 16'h0) begin n_errors++; $display("FAIL rst_ctl: got %h expected 0000", ctl); end
    n_checks++;
    if (bus.state !== 4'd0 || bus.instr_count !== 16'd0 || bus.illegal_op !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_regs: state=%0d cnt=%0d ill=%b expected 0/0/0", bus.state, bus.instr_count, bus.illegal_op);
    end
    // Retire one jump so that the later reset has a count to clear.
    rst = 1'b0;
    bus.opcode = OP_J;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.instr_count !== 16'd1) begin n_errors++; $display("FAIL rst_precount: got %0d expected 1", bus.instr_count); end
    // lw that stalls in MEMRD, then gets reset.
    bus.opcode = OP_LW;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = mr[i];
      #1;
      n_checks++;
      if (bus.state !== es[i]) begin n_errors++; $display("FAIL rst_lw_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.state !== 4'd3 || ctl !== 16'h0) begin
      n_errors++;
      $display("FAIL rst_forced: state=%0d ctl=%h expected 3/0000", bus.state, ctl);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.state !== 4'd0 || ctl !== 16'h0) begin
      n_errors++;
      $display("FAIL rst_hold: state=%0d ctl=%h expected 0/0000", bus.state, ctl);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    exp_cnt = 0;
    n_checks++;
    if (bus.state !== 4'd0 || bus.instr_count !== 16'd0 || bus.illegal_op !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_release: state=%0d cnt=%0d ill=%b expected 0/0/0", bus.state, bus.instr_count, bus.illegal_op);
    end
    n_checks++;
    if (ctl !== exp_ctl(4'd0, 1'b1)) begin n_errors++; $display("FAIL rst_fetch_ctl: got %h expected %h", ctl, exp_ctl(4'd0, 1'b1)); end
  endtask

  task automatic test_lw();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    bus.opcode = OP_LW;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = 1'b1;
      if (i >= 2) bus.opcode = OP_SW;
      #1;
      n_checks++;
      if (bus.state !== es[i]) begin n_errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      n_checks++;
      if (ctl !== exp_ctl(es[i], 1'b1)) begin n_errors++; $display("FAIL lw_ctl[%0d]: got %h expected %h", i, ctl, exp_ctl(es[i], 1'b1)); end
      n_checks++;
      if (bus.instr_count !== exp_cnt[15:0]) begin n_errors++; $display("FAIL lw_cnt[%0d]: got %0d expected %0d", i, bus.instr_count, exp_cnt); end
      n_checks++;
      if (bus.RegWrite && (bus.MemRead || bus.MemWrite)) begin n_errors++; $display("FAIL lw_excl[%0d]: got ctl %h expected no RegWrite with strobe", i, ctl); end
      @(negedge clk);
    end
    exp_cnt++;
    #1;
    n_checks++;
    if (bus.state !== 4'd0 || bus.instr_count !== exp_cnt[15:0]) begin
      n_errors++;
      $display("FAIL lw_done: state=%0d cnt=%0d expected 0/%0d", bus.state, bus.instr_count, exp_cnt);
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0] es [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    logic       mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int n_mw = 0;
    bus.opcode = OP_SW;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = mr[i];
      #1;
      n_checks++;
      if (bus.state !== es[i]) begin n_errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      n_checks++;
      if (ctl !== exp_ctl(es[i], mr[i])) begin n_errors++; $display("FAIL sw_ctl[%0d]: got %h expected %h", i, ctl, exp_ctl(es[i], mr[i])); end
      n_checks++;
      if (bus.MemRead && bus.MemWrite) begin n_errors++; $display("FAIL sw_excl[%0d]: got MemRead=MemWrite=1 expected exclusive", i); end
      if (bus.MemWrite) n_mw++;
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    exp_cnt++;
    #1;
    n_checks++;
    if (n_mw != 4) begin n_errors++; $display("FAIL sw_memwrite_cycles: got %0d expected 4", n_mw); end
    n_checks++;
    if (bus.state !== 4'd0 || bus.instr_count !== exp_cnt[15:0]) begin
      n_errors++;
      $display("FAIL sw_done: state=%0d cnt=%0d expected 0/%0d", bus.state, bus.instr_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [14] = '{OP_R, OP_R, OP_R, OP_R, OP_BEQ, OP_BEQ, OP_BEQ,
                             OP_J, OP_J, OP_J, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
    logic [3:0] es  [14] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8,
                             4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd10, 4'd11};
    int start_cnt = exp_cnt;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.opcode = ops[i];
      #1;
      n_checks++;
      if (bus.state !== es[i]) begin n_errors++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      n_checks++;
      if (ctl !== exp_ctl(es[i], 1'b1)) begin n_errors++; $display("FAIL b2b_ctl[%0d]: got %h expected %h", i, ctl, exp_ctl(es[i], 1'b1)); end
      @(negedge clk);
    end
    exp_cnt = start_cnt + 4;
    #1;
    n_checks++;
    if (bus.state !== 4'd0 || bus.instr_count !== exp_cnt[15:0]) begin
      n_errors++;
      $display("FAIL b2b_done: state=%0d cnt=%0d expected 0/%0d", bus.state, bus.instr_count, exp_cnt);
    end
  endtask

  task automatic test_fetch_stall();
    logic [3:0] es [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd9};
    logic       mr [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.opcode = OP_J;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = mr[i];
      #1;
      n_checks++;
      if (bus.state !== es[i]) begin n_errors++; $display("FAIL stall_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      n_checks++;
      if (ctl !== exp_ctl(es[i], mr[i])) begin n_errors++; $display("FAIL stall_ctl[%0d]: got %h expected %h", i, ctl, exp_ctl(es[i], mr[i])); end
      @(negedge clk);
    end
    exp_cnt++;
    #1;
    n_checks++;
    if (bus.instr_count !== exp_cnt[15:0]) begin n_errors++; $display("FAIL stall_cnt: got %0d expected %0d", bus.instr_count, exp_cnt); end
  endtask

  task automatic test_illegal();
    bus.mem_ready = 1'b1;
    bus.opcode = OP_BAD;
    #1;
    n_checks++;
    if (bus.illegal_op !== 1'b0) begin n_errors++; $display("FAIL ill_pre: got %b expected 0", bus.illegal_op); end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.state !== 4'd1 || bus.illegal_op !== 1'b0) begin
      n_errors++;
      $display("FAIL ill_decode: state=%0d ill=%b expected 1/0", bus.state, bus.illegal_op);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.state !== 4'd0 || bus.illegal_op !== 1'b1 || bus.instr_count !== exp_cnt[15:0]) begin
      n_errors++;
      $display("FAIL ill_set: state=%0d ill=%b cnt=%0d expected 0/1/%0d", bus.state, bus.illegal_op, bus.instr_count, exp_cnt);
    end
    bus.opcode = OP_J;
    repeat (3) @(negedge clk);
    exp_cnt++;
    #1;
    n_checks++;
    if (bus.illegal_op !== 1'b1 || bus.instr_count !== exp_cnt[15:0]) begin
      n_errors++;
      $display("FAIL ill_sticky: ill=%b cnt=%0d expected 1/%0d", bus.illegal_op, bus.instr_count, exp_cnt);
    end
    bus.opcode = OP_BAD;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.state !== 4'd0 || bus.illegal_op !== 1'b1 || bus.instr_count !== exp_cnt[15:0]) begin
      n_errors++;
      $display("FAIL ill_again: state=%0d ill=%b cnt=%0d expected 0/1/%0d", bus.state, bus.illegal_op, bus.instr_count, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    int k;
    k = 15 - (exp_cnt % 16);
    bus.mem_ready = 1'b1;
    bus.opcode = OP_J;
    repeat (3 * k) @(negedge clk);
    exp_cnt += k;
    #1;
    n_checks++;
    if (bus_s.instr_count !== 4'hF) begin n_errors++; $display("FAIL wrap_allones: got %h expected f", bus_s.instr_count); end
    repeat (3) @(negedge clk);
    exp_cnt++;
    #1;
    n_checks++;
    if (bus_s.instr_count !== 4'h0) begin n_errors++; $display("FAIL wrap_zero: got %h expected 0", bus_s.instr_count); end
    n_checks++;
    if (bus.instr_count !== exp_cnt[15:0] || bus.state !== 4'd0) begin
      n_errors++;
      $display("FAIL wrap_main: cnt=%0d state=%0d expected %0d/0", bus.instr_count, bus.state, exp_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_R;
    repeat (2) @(negedge clk);
    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_fetch_stall();
    test_illegal();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
